// File: rtl/svm_cfg_loader.sv
// Configuration sequencer: streams SVM weights into the classifier weight RAM, loads the bias
// and gates the cell handshake until a complete configuration is held. Option: SVM_CFG_READBACK_EN.
module svm_cfg_loader #(
  parameter int CFG_DATA_W = 32,
  parameter int WEIGHT_NUM = 1024,
  parameter int RAM_ADDR_W = $clog2(WEIGHT_NUM),
  parameter int CNT_W      = $clog2(WEIGHT_NUM + 1)
) (
  input  logic                  s_aclk,
  input  logic                  s_aresetn,
  input  logic [CFG_DATA_W-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  output logic                  s_tready_o,
  output logic [RAM_ADDR_W-1:0] addr_a_o,
  output logic                  write_en_o,
  output logic [CFG_DATA_W-1:0] data_a_o,
  input  logic [CFG_DATA_W-1:0] data_a_i,
  output logic [CFG_DATA_W-1:0] bias_o,
  output logic                  b_load_o,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  input  logic                  cell_valid_i,
  output logic                  cell_ready_o,
  output logic                  hog_ready_o,
  input  logic                  hog_request_i
);

`ifdef SVM_CFG_READBACK_EN
  localparam int CW = CNT_W + 1;
  typedef enum logic [2:0] {ST_LOAD, ST_BIAS, ST_VERIFY, ST_DONE, ST_DRAIN} state_t;
`else
  localparam int CW = CNT_W;
  typedef enum logic [2:0] {ST_LOAD, ST_BIAS, ST_DONE, ST_DRAIN} state_t;
`endif

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d, bload_q, bload_d, done_q, done_d, err_q, err_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [CFG_DATA_W-1:0] wdata_q, wdata_d, bias_q, bias_d;
  logic                  ready, hs;
`ifdef SVM_CFG_READBACK_EN
  logic [CFG_DATA_W-1:0] wx_q, wx_d, rx_q, rx_d;
`else
  logic                  unused_rd;
  assign unused_rd = ^data_a_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bias_d  = bias_q;
    bload_d = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
`ifdef SVM_CFG_READBACK_EN
    wx_d    = wx_q;
    rx_d    = rx_q;
    ready   = (state_q != ST_VERIFY);
`else
    ready   = 1'b1;
`endif
    hs = s_tvalid_i & ready;
    unique case (state_q)
      // DONE is always held with cnt=0, so a beat there is the first beat of a new attempt
      ST_LOAD, ST_DONE: begin
        if (hs) begin
          if (cnt_q == '0) begin
            done_d = 1'b0;
            err_d  = 1'b0;
          end
          if (s_tlast_i) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            we_d    = 1'b1;
            addr_d  = cnt_q[RAM_ADDR_W-1:0];
            wdata_d = s_tdata_i;
`ifdef SVM_CFG_READBACK_EN
            wx_d    = (cnt_q == '0) ? s_tdata_i : (wx_q ^ s_tdata_i);
`endif
            if (cnt_q == CW'(WEIGHT_NUM - 1)) begin
              cnt_d   = '0;
              state_d = ST_BIAS;
            end else begin
              cnt_d   = cnt_q + CW'(1);
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_BIAS: begin
        if (hs) begin
          if (s_tlast_i) begin
            bias_d  = s_tdata_i;
            bload_d = 1'b1;
`ifdef SVM_CFG_READBACK_EN
            state_d = ST_VERIFY;
            cnt_d   = '0;
            addr_d  = '0;
            rx_d    = '0;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
`ifdef SVM_CFG_READBACK_EN
      // cnt steps 0..N+1: address k issued at step k, its data folded in at step k+1,
      // and the final step compares the two checksums
      ST_VERIFY: begin
        if (cnt_q != '0 && cnt_q <= CW'(WEIGHT_NUM)) rx_d = rx_q ^ data_a_i;
        if (cnt_q == CW'(WEIGHT_NUM + 1)) begin
          cnt_d = '0;
          if (rx_q == wx_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q < CW'(WEIGHT_NUM - 1)) addr_d = RAM_ADDR_W'(cnt_q + CW'(1));
        end
      end
`endif
      ST_DRAIN: begin
        if (hs && s_tlast_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bias_q  <= '0;
      bload_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SVM_CFG_READBACK_EN
      wx_q    <= '0;
      rx_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bias_q  <= bias_d;
      bload_q <= bload_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SVM_CFG_READBACK_EN
      wx_q    <= wx_d;
      rx_q    <= rx_d;
`endif
    end
  end

  assign s_tready_o   = ready;
  assign write_en_o   = we_q;
  assign addr_a_o     = addr_q;
  assign data_a_o     = wdata_q;
  assign bias_o       = bias_q;
  assign b_load_o     = bload_q;
  assign cfg_done_o   = done_q;
  assign cfg_err_o    = err_q;
  assign hog_ready_o  = cell_valid_i & done_q;
  assign cell_ready_o = hog_request_i & done_q;

endmodule

// File: tb/tb_svm_cfg_loader.sv
// Bench for svm_cfg_loader: packet-level reference model checked every cycle, plus directed
// literal checks; covers SVM_CFG_READBACK_EN when that macro is defined.
module tb_svm_cfg_loader;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0;
  logic cell_valid = 1'b0, hog_request = 1'b0;
  logic s_tready_o, write_en_o, b_load_o, cfg_done_o, cfg_err_o, cell_ready_o, hog_ready_o;
  logic [AW-1:0] addr_a_o;
  logic [DW-1:0] data_a_o, bias_o, data_a_i;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  svm_cfg_loader #(.CFG_DATA_W(DW), .WEIGHT_NUM(N)) dut (
    .s_aclk(clk), .s_aresetn(rst_n),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready_o),
    .addr_a_o(addr_a_o), .write_en_o(write_en_o), .data_a_o(data_a_o), .data_a_i(data_a_i),
    .bias_o(bias_o), .b_load_o(b_load_o), .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
    .cell_valid_i(cell_valid), .cell_ready_o(cell_ready_o),
    .hog_ready_o(hog_ready_o), .hog_request_i(hog_request)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // weight RAM with 1-cycle read latency; corrupt flips bits of word 2 on read
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_q = '0;
  bit corrupt = 1'b0;
  function automatic logic [DW-1:0] ram_word(input int unsigned a);
    logic [DW-1:0] w;
    w = mem[a[AW-1:0]];
    if (corrupt && a == 2) w = w ^ 32'h0000_00FF;
    return w;
  endfunction
  always @(posedge clk) begin
    if (write_en_o) mem[addr_a_o] <= data_a_o;
    rd_q <= ram_word(int'(addr_a_o));
  end
  assign data_a_i = rd_q;

  // reference model: position of the next beat within the current packet
  int pos = 0;
  bit discard = 1'b0;
  int vleft = 0;
  bit acc;
  logic [DW-1:0] gx = '0, rx;
  logic e_we = 0, e_bl = 0, e_done = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0, e_bias = '0;
  logic e_ready;
  assign e_ready = (vleft == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = 0; discard = 0; vleft = 0; gx = '0;
      e_we = 0; e_bl = 0; e_done = 0; e_err = 0; e_addr = '0; e_data = '0; e_bias = '0;
    end else begin
      acc = s_tvalid && e_ready;
      e_we = 0;
      e_bl = 0;
      if (vleft > 0) begin
        vleft--;
        if (N + 2 - vleft <= N - 1) e_addr = AW'(N + 2 - vleft);
        if (vleft == 0) begin
          rx = '0;
          for (int i = 0; i < N; i++) rx ^= ram_word(i);
          if (rx == gx) e_done = 1; else e_err = 1;
        end
      end else if (acc) begin
        if (discard) begin
          if (s_tlast) begin discard = 0; pos = 0; end
        end else if (pos < N) begin
          if (pos == 0) begin e_done = 0; e_err = 0; gx = '0; end
          if (s_tlast) begin
            e_err = 1; pos = 0;
          end else begin
            e_we = 1; e_addr = AW'(pos); e_data = s_tdata; gx ^= s_tdata; pos++;
          end
        end else begin
          pos = 0;
          if (s_tlast) begin
            e_bias = s_tdata; e_bl = 1;
`ifdef SVM_CFG_READBACK_EN
            vleft = N + 2; e_addr = '0;
`else
            e_done = 1;
`endif
          end else begin
            e_err = 1; discard = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("tready", s_tready_o, e_ready);
    chk("write_en", write_en_o, e_we);
    chk("addr", addr_a_o, e_addr);
    chk("wdata", data_a_o, e_data);
    chk("bias", bias_o, e_bias);
    chk("b_load", b_load_o, e_bl);
    chk("cfg_done", cfg_done_o, e_done);
    chk("cfg_err", cfg_err_o, e_err);
    chk("hog_ready", hog_ready_o, cell_valid & e_done);
    chk("cell_ready", cell_ready_o, hog_request & e_done);
  end

  int wcnt = 0, blcnt = 0, cyc = 0, bl_cyc = 0, done_cyc = 0;
  logic done_prev = 0;
  always @(negedge clk) begin
    if (write_en_o) wcnt++;
    if (b_load_o) begin blcnt++; bl_cyc = cyc; end
    if (cfg_done_o && !done_prev) done_cyc = cyc;
    done_prev = cfg_done_o;
    cyc++;
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    int unsigned k;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (s_tready_o || k > 40) break;
      k++;
    end
    chk("tready_wait", s_tready_o, 1'b1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) send(base + DW'(i), 1'b0);
    send(base + 32'h100, 1'b1);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int p, k;
  logic [DW-1:0] base;

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_done", cfg_done_o, 1'b0);
    chk("rst_err", cfg_err_o, 1'b0);
    chk("rst_tready", s_tready_o, 1'b1);
    chk("rst_we", write_en_o, 1'b0);
    chk("rst_bload", b_load_o, 1'b0);
    cell_valid = 1'b1; hog_request = 1'b1;
    #1 chk("gate_pre_hog", hog_ready_o, 1'b0);
    chk("gate_pre_cell", cell_ready_o, 1'b0);
    cell_valid = 1'b0; hog_request = 1'b0;

    wcnt = 0; blcnt = 0;
    send(32'h11, 0); send(32'h22, 0); send(32'h33, 0); send(32'h44, 0); send(32'h5A, 1);
    idle(N + 4);
    chk("s1_writes", wcnt, 4);
    chk("s1_mem0", mem[0], 32'h11);
    chk("s1_mem1", mem[1], 32'h22);
    chk("s1_mem2", mem[2], 32'h33);
    chk("s1_mem3", mem[3], 32'h44);
    chk("s1_bias", bias_o, 32'h5A);
    chk("s1_bload", blcnt, 1);
    chk("s1_done", cfg_done_o, 1'b1);
    chk("s1_err", cfg_err_o, 1'b0);
`ifdef SVM_CFG_READBACK_EN
    chk("s1_done_lat", done_cyc - bl_cyc, 6);
`else
    chk("s1_done_lat", done_cyc - bl_cyc, 0);
`endif
    cell_valid = 1'b1; hog_request = 1'b1;
    #1 chk("gate_post_hog", hog_ready_o, 1'b1);
    chk("gate_post_cell", cell_ready_o, 1'b1);
    cell_valid = 1'b0; hog_request = 1'b0;

    wcnt = 0;
    send(32'hA1, 0); send(32'hA2, 0); send(32'hA3, 1);
    idle(2);
    chk("early_writes", wcnt, 2);
    chk("early_err", cfg_err_o, 1'b1);
    chk("early_done", cfg_done_o, 1'b0);
    chk("early_mem1", mem[1], 32'hA2);
    load(32'hB0);
    idle(N + 4);
    chk("early_reload_done", cfg_done_o, 1'b1);
    chk("early_reload_err", cfg_err_o, 1'b0);

    wcnt = 0; blcnt = 0;
    for (int i = 0; i < N; i++) send(32'hC0 + DW'(i), 0);
    send(32'hC5, 0); send(32'hC6, 0); send(32'hC7, 1);
    idle(2);
    chk("nolast_bload", blcnt, 0);
    chk("nolast_err", cfg_err_o, 1'b1);
    chk("nolast_done", cfg_done_o, 1'b0);
    chk("nolast_tready", s_tready_o, 1'b1);
    load(32'hD0);
    idle(N + 4);
    chk("nolast_reload_bias", bias_o, 32'h1D0);
    chk("nolast_reload_done", cfg_done_o, 1'b1);

    send(32'hE1, 0); send(32'hE2, 0);
    do_reset();
    chk("rstmid_done", cfg_done_o, 1'b0);
    chk("rstmid_tready", s_tready_o, 1'b1);
    load(32'hF0);
    idle(N + 4);
    chk("rstmid_reload_done", cfg_done_o, 1'b1);
    chk("rstmid_reload_err", cfg_err_o, 1'b0);

`ifdef SVM_CFG_READBACK_EN
    corrupt = 1'b1;
    load(32'h700);
    idle(N + 4);
    chk("rb_bad_err", cfg_err_o, 1'b1);
    chk("rb_bad_done", cfg_done_o, 1'b0);
    corrupt = 1'b0;
    load(32'h800);
    idle(N + 4);
    chk("rb_ok_done", cfg_done_o, 1'b1);
    chk("rb_ok_lat", done_cyc - bl_cyc, 6);
`endif

    for (int t = 0; t < 200; t++) begin
      cell_valid = 1'($urandom_range(0, 1));
      hog_request = 1'($urandom_range(0, 1));
      base = $urandom;
      case ($urandom_range(0, 3))
        0, 1: load(base);
        2: begin
          p = $urandom_range(0, N - 1);
          for (int i = 0; i < p; i++) send(base + DW'(i), 0);
          send(base ^ 32'hFFFF, 1);
        end
        default: begin
          for (int i = 0; i < N; i++) send(base + DW'(i), 0);
          k = $urandom_range(0, 3);
          for (int i = 0; i <= k; i++) send($urandom, 0);
          send($urandom, 1);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(N + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/svm_cfg_loader.md
# svm_cfg_loader

Configuration sequencer for the HOG/SVM classifier. It accepts an AXI-Stream of SVM weights followed by a bias word and writes the weights sequentially into the classifier's weight RAM port. It then loads the bias and holds the cell handshake between frame fetch and HOG closed until a complete, well-formed configuration is in place. It sits beside the image processor top level and drives the weight RAM, bias and cell-gating signals of the classifier.

## Interface
- CFG_DATA_W, 32, width of config stream beats, RAM words and bias
- WEIGHT_NUM, 1024, number of SVM weight words per configuration
- RAM_ADDR_W, $clog2(WEIGHT_NUM), weight RAM address width
- CNT_W, $clog2(WEIGHT_NUM+1), beat counter width
---
- s_aclk  in  1  clock
- s_aresetn  in  1  asynchronous active-low reset
- s_tdata_i  in  CFG_DATA_W  config beat data
- s_tvalid_i  in  1  config beat valid
- s_tlast_i  in  1  marks the bias beat (final beat of a configuration)
- s_tready_o  out  1  config beat ready
- addr_a_o  out  RAM_ADDR_W  weight RAM address
- write_en_o  out  1  weight RAM write strobe
- data_a_o  out  CFG_DATA_W  weight RAM write data
- data_a_i  in  CFG_DATA_W  weight RAM read data (1-cycle read latency)
- bias_o  out  CFG_DATA_W  registered bias value
- b_load_o  out  1  one-cycle bias load pulse
- cfg_done_o  out  1  valid configuration present
- cfg_err_o  out  1  last configuration attempt failed (sticky until next attempt)
- cell_valid_i  in  1  cell valid from frame fetch
- cell_ready_o  out  1  cell ready to frame fetch
- hog_ready_o  out  1  cell valid to HOG
- hog_request_i  in  1  cell request from HOG

## Operation
- States: LOAD (idle and weight loading share one state, counter cnt), BIAS, VERIFY (only with macro), DONE, DRAIN.
- Reset: state LOAD, cnt=0, all outputs 0 except s_tready_o=1.
- LOAD: s_tready_o=1. On handshake with cnt<WEIGHT_NUM, register write_en_o=1, addr_a_o=cnt, data_a_o=s_tdata_i, then cnt++. On the first beat of an attempt, clear cfg_done_o and cfg_err_o. When cnt reaches WEIGHT_NUM, go to BIAS.
- tlast on a weight beat: the weight is not written, cfg_err_o=1, cnt=0, stay in LOAD. An early tlast terminates the packet.
- BIAS: s_tready_o=1. On handshake with tlast=1, set bias_o=s_tdata_i and pulse b_load_o for one cycle, then go to VERIFY or DONE. On handshake with tlast=0, cfg_err_o=1 and go to DRAIN.
- DRAIN: s_tready_o=1. Discard beats until a tlast handshake, then go to LOAD with cnt=0.
- DONE: cfg_done_o=1, s_tready_o=1. Any accepted beat starts a new attempt exactly as in LOAD with cnt=0, and cfg_done_o drops the cycle after that handshake.
- Cell gating (combinational): hog_ready_o=cell_valid_i&cfg_done_o and cell_ready_o=hog_request_i&cfg_done_o. Both are 0 whenever no valid configuration is held.
- Bias width: bias_o is passed through unchanged. Addresses wrap only via cnt reset; there is no modulo arithmetic.

## Timing
- RAM write occurs the cycle after the beat handshake; write_en_o is high for exactly one cycle per accepted weight.
- Throughput is one beat per cycle, with no bubbles in LOAD, BIAS or DRAIN.
- b_load_o rises the cycle after the bias handshake. Without the macro, cfg_done_o rises in the same cycle as b_load_o.
- Asserting s_aresetn low mid-load aborts immediately. After release, cfg_done_o=0 and the RAM contents are undefined until the next full load.

## Configuration
- SVM_CFG_READBACK_EN defined:
  - A running XOR of all written weights is kept.
  - VERIFY drives addr_a_o=0..WEIGHT_NUM-1 with write_en_o=0 and s_tready_o=0, and XORs data_a_i one cycle after each address.
  - Match: go to DONE, with cfg_done_o rising WEIGHT_NUM+2 cycles after b_load_o.
  - Mismatch: cfg_err_o=1, go to LOAD.
- Not defined: the VERIFY state, XOR logic and the use of data_a_i are absent. BIAS goes straight to DONE.

## Test plan
- WEIGHT_NUM=4, beats 0x11,0x22,0x33,0x44, then bias 0x5A with tlast -> writes at addr 0..3 with matching data, b_load_o pulse with bias_o=0x5A, cfg_done_o=1, cfg_err_o=0.
- Gating: before configuration, cell_valid_i=1 -> hog_ready_o=0. After configuration, hog_ready_o=1 and hog_request_i=1 -> cell_ready_o=1.
- tlast on the 3rd weight -> only 2 writes, cfg_err_o=1, cfg_done_o=0. A following correct 5-beat load -> cfg_done_o=1, cfg_err_o=0.
- Bias beat without tlast, followed by 2 extra beats with the last carrying tlast -> no b_load_o, cfg_err_o=1, back in LOAD.
- Reset pulsed after 2 weights -> cfg_done_o=0 and s_tready_o=1. A full reload then succeeds.
- With SVM_CFG_READBACK_EN, the RAM model corrupts addr 2 -> cfg_err_o=1 and cfg_done_o=0. With a clean model, cfg_done_o rises 6 cycles after b_load_o.
